// File: rtl/alu.sv
// 32-bit integer ALU for the single-cycle MIPS datapath: combinational RES/ZERO
// from A, B and op, plus a registered status stage with add/sub carry and overflow flags.
`timescale 1ns/1ps
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] RES,
    output logic             ZERO,
    output logic [WIDTH-1:0] RES_Q,
    output logic             ZERO_Q,
    output logic             CARRY_Q,
    output logic             OVF_Q
);

    logic             do_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             slt;
    logic             sltu;
    logic             is_arith;
    logic [4:0]       shamt;

    // Both set-less-than codes share the adder in subtract mode.
    assign do_sub   = op[1] | op[3];
    assign b_eff    = do_sub ? ~B : B;
    assign sum_ext  = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, do_sub};
    assign sum      = sum_ext[WIDTH-1:0];
    assign carry    = sum_ext[WIDTH];
    assign ovf      = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign slt      = sum[WIDTH-1] ^ ovf;
    assign sltu     = ~carry;
    assign is_arith = (op[3:2] == 2'b00);
    assign shamt    = A[4:0];

    always_comb begin
        // NOTE: RES gets a default before the case so no path can infer a latch;
        // combinational logic uses blocking assignments.
        RES = '0;
        case (op)
            4'b0000, 4'b0001,
            4'b0010, 4'b0011: RES = sum;
            4'b0100:          RES = A & B;
            4'b0101:          RES = A | B;
            4'b0110:          RES = A ^ B;
            4'b0111:          RES = ~(A | B);
            4'b1000, 4'b1001: RES = {{(WIDTH-1){1'b0}}, sltu};
            4'b1010, 4'b1011: RES = {{(WIDTH-1){1'b0}}, slt};
            4'b1100:          RES = B << shamt;
            4'b1101:          RES = B >> shamt;
            4'b1110:          RES = $signed(B) >>> shamt;
            default:          RES = '0;
        endcase
    end

    assign ZERO = (RES == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RES_Q   <= '0;
            ZERO_Q  <= 1'b0;
            CARRY_Q <= 1'b0;
            OVF_Q   <= 1'b0;
        end else begin
            RES_Q   <= RES;
            ZERO_Q  <= ZERO;
            CARRY_Q <= is_arith & carry;
            OVF_Q   <= is_arith & ovf;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors push expectations into queues,
// independent monitors compare combinational and registered outputs.
`timescale 1ns/1ps
module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  op;
    logic [31:0] RES;
    logic        ZERO;
    logic [31:0] RES_Q;
    logic        ZERO_Q;
    logic        CARRY_Q;
    logic        OVF_Q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        carry;
        logic        ovf;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        carry;
        logic        ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t comb_q[$];
    exp_t reg_q[$];

    alu #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .op      (op),
        .RES     (RES),
        .ZERO    (ZERO),
        .RES_Q   (RES_Q),
        .ZERO_Q  (ZERO_Q),
        .CARRY_Q (CARRY_Q),
        .OVF_Q   (OVF_Q)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Combinational monitor: samples 80 ns after each posedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #80;
            if (comb_q.size() > 0) begin
                e = comb_q.pop_front();
                check({e.name, "_res"}, RES, e.res);
                check({e.name, "_zero"}, {31'b0, ZERO}, {31'b0, e.res == 32'h0});
            end
        end
    end

    // Registered monitor: samples 1 ns after the capturing posedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                check({e.name, "_res_q"}, RES_Q, e.res);
                check({e.name, "_zero_q"}, {31'b0, ZERO_Q}, {31'b0, e.res == 32'h0});
                check({e.name, "_carry_q"}, {31'b0, CARRY_Q}, {31'b0, e.carry});
                check({e.name, "_ovf_q"}, {31'b0, OVF_Q}, {31'b0, e.ovf});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // name, op, A, B, RES, CARRY_Q, OVF_Q
        vecs.push_back('{"add_wrap",   4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"sub_ovf",    4'b0010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1});
        vecs.push_back('{"sub_borrow", 4'b0010, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{"add_ovf",    4'b0001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{"sub_equal",  4'b0011, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{"slt_neg",    4'b1010, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"sltu_big",   4'b1000, 32'hFFFFFFFE, 32'h00000001, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"slt_min",    4'b1011, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"sltu_small", 4'b1001, 32'h00000001, 32'h80000000, 32'h00000001, 1'b0, 1'b0});
        vecs.push_back('{"slt_max",    4'b1010, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"and",        4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0});
        vecs.push_back('{"or",         4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0});
        vecs.push_back('{"xor",        4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0});
        vecs.push_back('{"nor",        4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0, 1'b0});
        vecs.push_back('{"sll",        4'b1100, 32'h00000004, 32'h80000010, 32'h00000100, 1'b0, 1'b0});
        vecs.push_back('{"srl",        4'b1101, 32'h00000004, 32'h80000010, 32'h08000001, 1'b0, 1'b0});
        vecs.push_back('{"sra",        4'b1110, 32'h00000004, 32'h80000010, 32'hF8000001, 1'b0, 1'b0});
        vecs.push_back('{"sll_shamt",  4'b1100, 32'hFFFFFFE3, 32'h00000001, 32'h00000008, 1'b0, 1'b0});
        vecs.push_back('{"sll_31",     4'b1100, 32'h0000001F, 32'h00000001, 32'h80000000, 1'b0, 1'b0});
        vecs.push_back('{"zero_op",    4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back('{"pre_reset",  4'b0010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1});

        reset = 1'b1;
        A     = 32'h0;
        B     = 32'h0;
        op    = 4'b0000;

        // Registered stage cleared while reset is held from time zero.
        #20;
        check("init_res_q", RES_Q, 32'h0);
        check("init_flags_q", {28'b0, ZERO_Q, CARRY_Q, OVF_Q, 1'b0}, 32'h0);
        check("init_comb_zero", {31'b0, ZERO}, 32'h1);
        @(posedge clk);
        #1;
        check("init_hold_res_q", RES_Q, 32'h0);
        #29;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #20;
            op = vecs[i].op;
            A  = vecs[i].a;
            B  = vecs[i].b;
            comb_q.push_back('{vecs[i].name, vecs[i].res, 1'b0, 1'b0});
            reg_q.push_back('{vecs[i].name, vecs[i].res, vecs[i].carry, vecs[i].ovf});
        end

        // Reset between clock edges while the registered stage holds non-zero values.
        @(posedge clk);
        #20;
        op = 4'b0000;
        A  = 32'h00000003;
        B  = 32'h00000004;
        comb_q.push_back('{"during_reset", 32'h00000007, 1'b0, 1'b0});
        #10;
        reset = 1'b1;
        #10;
        check("async_reset_res_q", RES_Q, 32'h0);
        check("async_reset_flags_q", {28'b0, ZERO_Q, CARRY_Q, OVF_Q, 1'b0}, 32'h0);
        @(posedge clk);
        #1;
        check("reset_hold_res_q", RES_Q, 32'h0);
        check("reset_hold_flags_q", {28'b0, ZERO_Q, CARRY_Q, OVF_Q, 1'b0}, 32'h0);
        #29;
        reset = 1'b0;
        #10;
        reg_q.push_back('{"first_capture", 32'h00000007, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        #90;
        check("scoreboard_drain", comb_q.size() + reg_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
